add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter: none; the operand width is fixed at 16 bits, processed as 4 nibbles.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on rising edge.
REQ-005 a  input  16  operand A; captured when start is accepted.
REQ-006 b  input  16  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in for add; captured when start is accepted.
REQ-008 sub  input  1  1 = A-B, 0 = A+B+cin; captured when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress (state RUN).
REQ-010 done  output  1  single-cycle pulse: result valid this cycle.
REQ-011 sum  output  16  result; holds until the next accepted start or reset.
REQ-012 cout  output  1  carry-out of bit 15 (for sub: 1 = no borrow).
REQ-013 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The block SHALL contain exactly one cla_adder_4 instance and SHALL time-multiplex it across the four nibbles; no other adder logic on the data path.
REQ-015 States: IDLE, RUN, DONE; rst forces IDLE.
REQ-016 IDLE or DONE with start=1 at an edge: latch a, b, cin, sub; nibble index := 0; go RUN.
REQ-017 IDLE or DONE with start=0: go/stay IDLE (DONE lasts exactly one cycle).
REQ-018 RUN: each edge feeds nibble [4i+3:4i] of A and B' (B' = ~b if sub else b) plus the carry register into the adder; write the adder's S into sum[4i+3:4i]; write the adder's Cout into the carry register; increment i.
REQ-019 Carry register initial value at accept: 1 if sub=1 (cin ignored), else cin.
REQ-020 RUN with i=3 at an edge: after the nibble-3 write go DONE; cout := the adder's Cout; ovf := (A[15] == B'[15]) && (sum[15] != A[15]).
REQ-021 Latency: start accepted at edge T -> RUN during cycles T..T+3 -> done=1 in the cycle after edge T+4; busy=1 exactly in those 4 RUN cycles.
REQ-022 start while in RUN SHALL be ignored; latched operands and the in-flight result are unaffected.
REQ-023 Inputs a, b, cin, sub may change freely after acceptance without affecting the result.
REQ-024 Back-to-back: start in the DONE cycle is accepted; done deasserts and busy asserts in the next cycle.
REQ-025 sum, cout, ovf SHALL be updated only by RUN writes; partial nibble writes during RUN are permitted to be visible on sum, and only the done cycle guarantees a valid sum.
REQ-026 busy and done SHALL never be high in the same cycle.

Reset
REQ-027 With rst=1 at an edge: state IDLE; busy=0, done=0, sum=16'h0000, cout=0, ovf=0; nibble index and carry register are 0.
REQ-028 rst SHALL take priority over start and over RUN progress; an operation interrupted by reset is discarded with no done pulse.
REQ-029 The first start accepted after reset is released SHALL complete normally with the REQ-021 latency.

Verification
REQ-030 Reset held 2 cycles -> busy=0, done=0, sum=0000, cout=0, ovf=0.
REQ-031 a=1234, b=4321, cin=0, sub=0 -> sum=5555, cout=0, ovf=0; done exactly 5 cycles after start edge; busy high 4 cycles.
REQ-032 a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, ovf=0; a=7FFF, b=0000, cin=1 -> sum=8000, cout=0, ovf=1.
REQ-033 sub=1: a=0005, b=0007 -> sum=FFFE, cout=0, ovf=0; a=8000, b=0001 -> sum=7FFF, cout=1, ovf=1; cin=1 ignored.
REQ-034 start=1 with a=0001, b=0001 during RUN of 1234+4321 -> ignored; result 5555, only one done pulse; then start on the done cycle with a=00FF, b=0001 -> done 5 cycles later with sum=0100.
REQ-035 rst pulsed in second RUN cycle -> outputs zero next cycle, no done; subsequent 0F0F+F0F0 -> sum=FFFF, cout=0.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// 16-bit add/subtract that reuses one 4-bit carry-lookahead adder over four nibbles.
// Start is accepted in IDLE/DONE, four RUN cycles follow, then a one-cycle done pulse.

module cla_adder_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module add_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_c;
  logic [1:0]  r_idx;
  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_ovf;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [3:0]  w_s;
  logic        w_co;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  cla_adder_4 u_cla (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .i_c (r_c),
    .o_s (w_s),
    .o_c (w_co)
  );

  // r_b holds B already inverted for subtract, so ovf compares against B'.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_c     <= 1'b0;
      r_idx   <= 2'd0;
      r_sum   <= 16'h0000;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub | cin;
            r_idx   <= 2'd0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_s;
          r_c   <= w_co;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_co;
            r_ovf   <= (r_a[15] == r_b[15]) && (w_s[3] != r_a[15]);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: latency, arithmetic corners, ignored start, back-to-back, reset abort.
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  add_seq_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present operands and raise start for one edge.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
  endtask

  // Steps negedge by negedge until done; optionally injects a stray start at sample inj.
  task automatic wait_done(input int inj, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = (n == inj);
      if (n == inj) begin a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; end
      else begin a = $urandom; b = $urandom; cin = $urandom; sub = $urandom; end
      if (busy) bcnt++;
      if (done) begin lat = n; start = 1'b0; return; end
    end
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tc, input logic ts,
                     input logic [15:0] es, input logic ec, input logic eo);
    int lat, bc;
    launch(ta, tb_, tc, ts);
    wait_done(0, lat, bc);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_busy"}, bc, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int lat, bc, dcnt;
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    check("done_single", done, 0);
    run("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("add_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Stray start in RUN must be ignored.
    @(negedge clk);
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(2, lat, bc);
    check("ign_lat", lat, 5);
    check("ign_sum", sum, 16'h5555);
    // Back-to-back start issued in the done cycle.
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", done, 0);
    check("b2b_busy_high", busy, 1);
    dcnt = 0;
    for (int n = 2; n <= 5; n++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        check("b2b_lat", n, 5);
      end
    end
    check("b2b_done_cnt", dcnt, 1);
    check("b2b_sum", sum, 16'h0100);
    check("b2b_cout", cout, 0);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 16'h0000);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run("post_rst", 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    check("busy_done_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
